sw_mailbox: RTL and testbench
=============================

SW_MAILBOX -- requirements
Module: sw_mailbox

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of switch ports (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, register and metadata width.
REQ-003 SHALL have parameter RXQ_DEPTH, default 4, per-port receive queue depth (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports chipselect, write, read  input  1 each  software bus controls.
REQ-007 SHALL have port address  input  4  word address.
REQ-008 SHALL have port writedata  input  DATA_W  software write data.
REQ-009 SHALL have port readdata  output  DATA_W  registered read data.
REQ-010 SHALL have port interface_in_valid  input  NUM_PORTS  per-port egress metadata strobe.
REQ-011 SHALL have port interface_in  input  NUM_PORTS*DATA_W  per-port egress metadata; port i in slice i.
REQ-012 SHALL have port interface_out_en  output  NUM_PORTS  one-hot write pulse to packet_val/ingress.
REQ-013 SHALL have port interface_out  output  DATA_W  data qualified by interface_out_en.
REQ-014 SHALL have port interface_out_ack  output  NUM_PORTS  pulse per consumed queue entry.
REQ-015 SHALL have port experimenting  output  1  high while CTRL == 2.

Function
REQ-016 SHALL decode: 0 CTRL (RW), 1 STATUS (RO), 2 OVF_CLR (W1C), 3 TSTAMP (RO), 4+i PORT[i] for i<NUM_PORTS; others read 0, writes ignored.
REQ-017 SHALL update CTRL on write to 0 the cycle after; experimenting combinational from CTRL.
REQ-018 SHALL, on write to PORT[i], assert interface_out_en[i] and interface_out=writedata for exactly one cycle, registered (latency 1); otherwise both 0.
REQ-019 SHALL push interface_in slice i into RXQ[i] on each cycle interface_in_valid[i] is high.
REQ-020 SHALL, on read of PORT[i] with RXQ[i] non-empty, return head entry on readdata next cycle, pop it, pulse interface_out_ack[i] that same next cycle.
REQ-021 SHALL, on read of PORT[i] with RXQ[i] empty, return 0, not pop, not pulse ack.
REQ-022 SHALL drive readdata 0 in any cycle following no read; read latency exactly 1.
REQ-023 SHALL return STATUS bits[NUM_PORTS-1:0]=queue non-empty, bits[2*NUM_PORTS-1:NUM_PORTS]=sticky overflow, rest 0.
REQ-024 SHALL, on push to full RXQ[i] without simultaneous pop, drop the entry and set overflow[i].
REQ-025 SHALL, on simultaneous push and pop of full RXQ[i], perform both, keep count full, not set overflow.
REQ-026 SHALL clear overflow[i] for each writedata bit NUM_PORTS+i set in an OVF_CLR write; a same-cycle new overflow wins (stays set).
REQ-027 SHALL wrap queue pointers modulo RXQ_DEPTH; occupancy 0..RXQ_DEPTH.
REQ-028 SHALL process simultaneous read and write of different addresses independently.

Reset
REQ-029 SHALL, on reset, clear CTRL, overflow, timestamp, all queues, readdata, interface_out_en, interface_out, interface_out_ack to 0.
REQ-030 SHALL let reset override any same-cycle push, pop or write; mid-operation contents lost.

Configuration
REQ-031 SHALL, with SW_MAILBOX_TSTAMP_EN defined, keep a DATA_W free-running cycle counter (wraps to 0) readable at TSTAMP.
REQ-032 SHALL, without SW_MAILBOX_TSTAMP_EN, omit the counter; TSTAMP reads 0.

Structure
REQ-033 SHALL place address constants, CTRL_EXPERIMENT=2 and STATUS field offsets in package sw_mailbox_pkg.
REQ-034 SHALL instantiate one sub-module mailbox_fifo per port (DATA_W x RXQ_DEPTH, push/pop/full/empty, simultaneous push+pop on full).

Verification
REQ-035 SHALL cover: write 0x2 to addr 0 -> experimenting=1 next cycle; write 0x0 -> 0.
REQ-036 SHALL cover: write 0xDEADBEEF to addr 6 -> interface_out_en=4'b0100, interface_out=0xDEADBEEF one cycle, then 0.
REQ-037 SHALL cover: push 0x11,0x22 on port 0; read addr 4 twice -> readdata 0x11 then 0x22, ack[0] pulses twice; third read -> 0, no ack.
REQ-038 SHALL cover: 5 pushes to port 1 (depth 4) -> STATUS bit 5 set, reads return first 4 entries; write 0x20 to addr 2 -> bit 5 clear.
REQ-039 SHALL cover: port 2 full, push 0x99 with same-cycle pop -> no overflow, fifth read returns 0x99.
REQ-040 SHALL cover: reset asserted with queues full -> STATUS reads 0; with macro, TSTAMP reads N-1 after N cycles post-reset.

Source files
------------

// File: rtl/sw_mailbox_pkg.sv
// Shared constants and register decode for the switch mailbox.
package sw_mailbox_pkg;

    localparam logic [3:0] ADDR_CTRL      = 4'd0;
    localparam logic [3:0] ADDR_STATUS    = 4'd1;
    localparam logic [3:0] ADDR_OVF_CLR   = 4'd2;
    localparam logic [3:0] ADDR_TSTAMP    = 4'd3;
    localparam logic [3:0] ADDR_PORT_BASE = 4'd4;

    localparam int CTRL_EXPERIMENT     = 2;
    localparam int STATUS_NONEMPTY_LSB = 0;

    typedef enum logic [2:0] {
        SEL_CTRL    = 3'd0,
        SEL_STATUS  = 3'd1,
        SEL_OVF_CLR = 3'd2,
        SEL_TSTAMP  = 3'd3,
        SEL_PORT    = 3'd4,
        SEL_NONE    = 3'd5
    } reg_sel_e;

    // Overflow flags sit directly above the per-port non-empty flags.
    function automatic int status_ovf_lsb(input int num_ports);
        return STATUS_NONEMPTY_LSB + num_ports;
    endfunction

    function automatic reg_sel_e decode_addr(input logic [3:0] addr, input int num_ports);
        reg_sel_e sel;
        case (addr)
            ADDR_CTRL:    sel = SEL_CTRL;
            ADDR_STATUS:  sel = SEL_STATUS;
            ADDR_OVF_CLR: sel = SEL_OVF_CLR;
            ADDR_TSTAMP:  sel = SEL_TSTAMP;
            default:      sel = ((int'(addr) - int'(ADDR_PORT_BASE)) < num_ports) ? SEL_PORT : SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sw_mailbox_fifo.sv
// Per-port receive queue; a push into a full queue is accepted only when a pop frees a slot the same cycle.
module mailbox_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d, rd_ptr_q;
    logic [PTR_W:0]    count_d, count_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_ok, pop_ok;

    // Occupancy flags, accepted push/pop and next pointer/count values.
    always_comb begin
        empty    = (count_q == {(PTR_W+1){1'b0}});
        full     = (count_q == (PTR_W+1)'(DEPTH));
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        dout = mem_q[rd_ptr_q];
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless once count is cleared.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sw_mailbox.sv
// Software mailbox between a CPU bus and the switch ports.
// Optional free-running timestamp at TSTAMP when SW_MAILBOX_TSTAMP_EN is defined.
module sw_mailbox
    import sw_mailbox_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int RXQ_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic                          read,
    input  logic [3:0]                    address,
    input  logic [DATA_W-1:0]             writedata,
    output logic [DATA_W-1:0]             readdata,
    input  logic [NUM_PORTS-1:0]          interface_in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0]   interface_in,
    output logic [NUM_PORTS-1:0]          interface_out_en,
    output logic [DATA_W-1:0]             interface_out,
    output logic [NUM_PORTS-1:0]          interface_out_ack,
    output logic                          experimenting
);
    localparam int OVF_LSB = status_ovf_lsb(NUM_PORTS);

    logic [DATA_W-1:0]    ctrl_d, ctrl_q;
    logic [NUM_PORTS-1:0] ovf_d, ovf_q;
    logic [DATA_W-1:0]    readdata_d, readdata_q;
    logic [NUM_PORTS-1:0] out_en_d, out_en_q;
    logic [DATA_W-1:0]    out_d, out_q;
    logic [NUM_PORTS-1:0] ack_d, ack_q;

    logic                 wr_en, rd_en;
    reg_sel_e             sel;
    logic [3:0]           port_idx;
    logic [NUM_PORTS-1:0] port_hit, pop_s, new_ovf, ovf_clr;
    logic [NUM_PORTS-1:0] fifo_full, fifo_empty;
    logic [DATA_W-1:0]    fifo_dout [NUM_PORTS];
    logic [DATA_W-1:0]    status, rd_mux;

`ifdef SW_MAILBOX_TSTAMP_EN
    logic [DATA_W-1:0] tstamp_d, tstamp_q;

    // Free-running cycle counter, wraps naturally at 2**DATA_W.
    always_comb begin
        tstamp_d = tstamp_q + DATA_W'(1);
    end

    // Timestamp register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tstamp_q <= {DATA_W{1'b0}};
        end else begin
            tstamp_q <= tstamp_d;
        end
    end
`else
    logic [DATA_W-1:0] tstamp_q;
    assign tstamp_q = {DATA_W{1'b0}};
`endif

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rxq
        mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(RXQ_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (interface_in_valid[i]),
            .pop   (pop_s[i]),
            .din   (interface_in[i*DATA_W +: DATA_W]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    // Bus decode, queue pops, overflow tracking and next register values.
    always_comb begin
        wr_en    = chipselect & write;
        rd_en    = chipselect & read;
        sel      = decode_addr(address, NUM_PORTS);
        port_idx = address - ADDR_PORT_BASE;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_hit[i] = (sel == SEL_PORT) && (port_idx == 4'(i));
        end

        pop_s   = rd_en ? (port_hit & ~fifo_empty) : {NUM_PORTS{1'b0}};
        ack_d   = pop_s;
        new_ovf = interface_in_valid & fifo_full & ~pop_s;
        ovf_clr = (wr_en && sel == SEL_OVF_CLR) ? writedata[OVF_LSB +: NUM_PORTS] : {NUM_PORTS{1'b0}};
        ovf_d   = (ovf_q & ~ovf_clr) | new_ovf;

        ctrl_d   = (wr_en && sel == SEL_CTRL) ? writedata : ctrl_q;
        out_en_d = wr_en ? port_hit : {NUM_PORTS{1'b0}};
        out_d    = (wr_en && sel == SEL_PORT) ? writedata : {DATA_W{1'b0}};

        status = {DATA_W{1'b0}};
        status[STATUS_NONEMPTY_LSB +: NUM_PORTS] = ~fifo_empty;
        status[OVF_LSB +: NUM_PORTS]             = ovf_q;

        // An empty queue reads as zero rather than its stale head slot.
        rd_mux = {DATA_W{1'b0}};
        case (sel)
            SEL_CTRL:   rd_mux = ctrl_q;
            SEL_STATUS: rd_mux = status;
            SEL_TSTAMP: rd_mux = tstamp_q;
            SEL_PORT: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    rd_mux = rd_mux | (fifo_dout[i] & {DATA_W{port_hit[i] & ~fifo_empty[i]}});
                end
            end
            default:    rd_mux = {DATA_W{1'b0}};
        endcase
        readdata_d = rd_en ? rd_mux : {DATA_W{1'b0}};
    end

    // Register state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= {DATA_W{1'b0}};
            ovf_q      <= {NUM_PORTS{1'b0}};
            readdata_q <= {DATA_W{1'b0}};
            out_en_q   <= {NUM_PORTS{1'b0}};
            out_q      <= {DATA_W{1'b0}};
            ack_q      <= {NUM_PORTS{1'b0}};
        end else begin
            ctrl_q     <= ctrl_d;
            ovf_q      <= ovf_d;
            readdata_q <= readdata_d;
            out_en_q   <= out_en_d;
            out_q      <= out_d;
            ack_q      <= ack_d;
        end
    end

    assign readdata          = readdata_q;
    assign interface_out_en  = out_en_q;
    assign interface_out     = out_q;
    assign interface_out_ack = ack_q;
    assign experimenting     = (ctrl_q == DATA_W'(CTRL_EXPERIMENT));

endmodule

// File: tb/tb_sw_mailbox.sv
// Directed vector bench for sw_mailbox (NUM_PORTS=4, DATA_W=32, RXQ_DEPTH=4).
module tb_sw_mailbox;

    logic         clk = 1'b0;
    logic         reset;
    logic         chipselect, write, read;
    logic [3:0]   address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [3:0]   interface_in_valid;
    logic [127:0] interface_in;
    logic [3:0]   interface_out_en;
    logic [31:0]  interface_out;
    logic [3:0]   interface_out_ack;
    logic         experimenting;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sw_mailbox #(.NUM_PORTS(4), .DATA_W(32), .RXQ_DEPTH(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .chipselect         (chipselect),
        .write              (write),
        .read               (read),
        .address            (address),
        .writedata          (writedata),
        .readdata           (readdata),
        .interface_in_valid (interface_in_valid),
        .interface_in       (interface_in),
        .interface_out_en   (interface_out_en),
        .interface_out      (interface_out),
        .interface_out_ack  (interface_out_ack),
        .experimenting      (experimenting)
    );

    typedef struct {
        logic        rst;
        logic        cs, wr, rd;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  iv;
        logic [31:0] idata;
        logic [31:0] e_rd;
        logic [3:0]  e_en;
        logic [31:0] e_out;
        logic [3:0]  e_ack;
        logic        e_exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic cs, input logic wr, input logic rd,
                                input logic [3:0] addr, input logic [31:0] wdata,
                                input logic [3:0] iv, input logic [31:0] idata,
                                input logic [31:0] e_rd, input logic [3:0] e_en,
                                input logic [31:0] e_out, input logic [3:0] e_ack, input logic e_exp);
        vec_t v;
        v.rst = 1'b0; v.cs = cs; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
        v.iv = iv; v.idata = idata; v.e_rd = e_rd; v.e_en = e_en; v.e_out = e_out;
        v.e_ack = e_ack; v.e_exp = e_exp; v.name = name;
        return v;
    endfunction

    // Drive one cycle of inputs, then compare all outputs just after the edge.
    task automatic apply(input vec_t v);
        reset              = v.rst;
        chipselect         = v.cs;
        write              = v.wr;
        read               = v.rd;
        address            = v.addr;
        writedata          = v.wdata;
        interface_in_valid = v.iv;
        interface_in       = {4{v.idata}};
        @(posedge clk);
        #1;
        n_vec++;
        if ({readdata, interface_out_en, interface_out, interface_out_ack, experimenting} !==
            {v.e_rd, v.e_en, v.e_out, v.e_ack, v.e_exp}) begin
            n_bad++;
            $display("FAIL %s: got rd=%h en=%b out=%h ack=%b exp=%b, want rd=%h en=%b out=%h ack=%b exp=%b",
                     v.name, readdata, interface_out_en, interface_out, interface_out_ack, experimenting,
                     v.e_rd, v.e_en, v.e_out, v.e_ack, v.e_exp);
        end
    endtask

    initial begin
        vec_t v;
        logic [31:0] t0;

        vecs.push_back(mk("idle_after_reset", 0,0,0, 4'd0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("status_reset",     1,0,1, 4'd1, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("ctrl_reset",       1,0,1, 4'd0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("ctrl_wr_2",        1,1,0, 4'd0, 32'h2, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b1));
        vecs.push_back(mk("ctrl_rd_2",        1,0,1, 4'd0, 32'h0, 4'h0, 32'h0, 32'h2, 4'h0, 32'h0, 4'h0, 1'b1));
        vecs.push_back(mk("ctrl_wr_0",        1,1,0, 4'd0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("port2_wr",         1,1,0, 4'd6, 32'hDEADBEEF, 4'h0, 32'h0, 32'h0, 4'b0100, 32'hDEADBEEF, 4'h0, 1'b0));
        vecs.push_back(mk("port2_wr_gone",    0,0,0, 4'd0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("p0_push_11",       0,0,0, 4'd0, 32'h0, 4'h1, 32'h11, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("p0_push_22",       0,0,0, 4'd0, 32'h0, 4'h1, 32'h22, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("p0_rd_11",         1,0,1, 4'd4, 32'h0, 4'h0, 32'h0, 32'h11, 4'h0, 32'h0, 4'h1, 1'b0));
        vecs.push_back(mk("p0_rd_22",         1,0,1, 4'd4, 32'h0, 4'h0, 32'h0, 32'h22, 4'h0, 32'h0, 4'h1, 1'b0));
        vecs.push_back(mk("p0_rd_empty",      1,0,1, 4'd4, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        for (int i = 1; i <= 5; i++) begin
            vecs.push_back(mk("p1_push", 0,0,0, 4'd0, 32'h0, 4'h2, 32'hA0 + i, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        end
        vecs.push_back(mk("status_p1_ovf",    1,0,1, 4'd1, 32'h0, 4'h0, 32'h0, 32'h22, 4'h0, 32'h0, 4'h0, 1'b0));
        for (int i = 1; i <= 4; i++) begin
            vecs.push_back(mk("p1_rd", 1,0,1, 4'd5, 32'h0, 4'h0, 32'h0, 32'hA0 + i, 4'h0, 32'h0, 4'h2, 1'b0));
        end
        vecs.push_back(mk("status_p1_drain",  1,0,1, 4'd1, 32'h0, 4'h0, 32'h0, 32'h20, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("ovf_clr_p1",       1,1,0, 4'd2, 32'h20, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("status_p1_clr",    1,0,1, 4'd1, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        for (int i = 1; i <= 4; i++) begin
            vecs.push_back(mk("p2_push", 0,0,0, 4'd0, 32'h0, 4'h4, 32'hB0 + i, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        end
        vecs.push_back(mk("p2_full_push_pop", 1,0,1, 4'd6, 32'h0, 4'h4, 32'h99, 32'hB1, 4'h0, 32'h0, 4'h4, 1'b0));
        vecs.push_back(mk("status_p2_no_ovf", 1,0,1, 4'd1, 32'h0, 4'h0, 32'h0, 32'h04, 4'h0, 32'h0, 4'h0, 1'b0));
        for (int i = 2; i <= 4; i++) begin
            vecs.push_back(mk("p2_rd", 1,0,1, 4'd6, 32'h0, 4'h0, 32'h0, 32'hB0 + i, 4'h0, 32'h0, 4'h4, 1'b0));
        end
        vecs.push_back(mk("p2_rd_99",         1,0,1, 4'd6, 32'h0, 4'h0, 32'h0, 32'h99, 4'h0, 32'h0, 4'h4, 1'b0));
        vecs.push_back(mk("p2_rd_empty",      1,0,1, 4'd6, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        for (int i = 1; i <= 4; i++) begin
            vecs.push_back(mk("p3_push", 0,0,0, 4'd0, 32'h0, 4'h8, 32'hC0 + i, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        end
        vecs.push_back(mk("p3_clr_vs_ovf",    1,1,0, 4'd2, 32'h80, 4'h8, 32'hC5, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("status_ovf_wins",  1,0,1, 4'd1, 32'h0, 4'h0, 32'h0, 32'h88, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("ovf_clr_p3",       1,1,0, 4'd2, 32'h80, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("status_p3_clr",    1,0,1, 4'd1, 32'h0, 4'h0, 32'h0, 32'h08, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("wr_unmapped",      1,1,0, 4'd12, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("rd_unmapped",      1,0,1, 4'd12, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        vecs.push_back(mk("rd_cs_low",        0,0,1, 4'd0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
`ifndef SW_MAILBOX_TSTAMP_EN
        vecs.push_back(mk("tstamp_absent",    1,0,1, 4'd3, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
`endif

        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0; address = 4'd0;
        writedata = 32'h0; interface_in_valid = 4'h0; interface_in = 128'h0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Reset with port 3 still full, plus a same-cycle push and port write that must be lost.
        v = mk("reset_overrides", 1,1,0, 4'd7, 32'h12345678, 4'h8, 32'h77, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0);
        v.rst = 1'b1;
        apply(v);
        apply(mk("status_after_rst", 1,0,1, 4'd1, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));
        apply(mk("p3_rd_after_rst",  1,0,1, 4'd7, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0));

`ifdef SW_MAILBOX_TSTAMP_EN
        // Back-to-back TSTAMP reads must differ by exactly one cycle.
        apply(mk("tstamp_rd0", 1,0,1, 4'd3, 32'h0, 4'h0, 32'h0, 32'd2, 4'h0, 32'h0, 4'h0, 1'b0));
        t0 = readdata;
        apply(mk("tstamp_rd1", 1,0,1, 4'd3, 32'h0, 4'h0, 32'h0, t0 + 32'd1, 4'h0, 32'h0, 4'h0, 1'b0));
`else
        t0 = 32'h0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
